// File: rtl/adf4159_spi_writer.sv
// rtl/adf4159_spi_writer.sv - MSB-first 32-bit register writer for the ADF4159 PLL chips
// Optional post-R0 lock wait is built when ADF4159_LOCK_WAIT_EN is defined.
module adf4159_spi_writer #(
    parameter int NUM_DEV      = 6,
    parameter int CLK_DIV      = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_dev,
    input  logic [31:0]        wr_data,
    output logic [NUM_DEV-1:0] adf4159_clk,
    output logic [NUM_DEV-1:0] adf4159_data,
    output logic [NUM_DEV-1:0] adf4159_le,
    input  logic [NUM_DEV-1:0] pll_lock,
    output logic               busy,
    output logic               err_dev,
    output logic [NUM_DEV-1:0] lock_timeout
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LOCK_WAIT} state_t;
    state_t state, state_nxt;

    logic [2:0]       dev;
    logic [31:0]      word;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             phase_high;
    logic             accept, dev_ok, div_last, frame;
    logic             lock_seen, lock_expired, lock_wait_req;

    assign accept   = wr_valid && wr_ready;
    assign dev_ok   = ({29'd0, wr_dev} < 32'(NUM_DEV));
    assign div_last = (div_cnt == DIV_LAST);
    // le is held low for the selected chip across SETUP, SHIFT and HOLD
    assign frame    = (state == SETUP) || (state == SHIFT) || (state == HOLD);

`ifdef ADF4159_LOCK_WAIT_EN
    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

    logic [NUM_DEV-1:0] lock_meta, lock_sync;
    logic [LCW-1:0]     lock_cnt;

    assign lock_seen     = lock_sync[dev];
    assign lock_expired  = (lock_cnt == LOCK_LAST);
    assign lock_wait_req = (word[2:0] == 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta    <= '0;
            lock_sync    <= '0;
            lock_cnt     <= '0;
            lock_timeout <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            if (state == LOCK_WAIT) begin
                lock_cnt <= lock_cnt + 1'b1;
                if (lock_seen)
                    lock_timeout[dev] <= 1'b0;
                else if (lock_expired)
                    lock_timeout[dev] <= 1'b1;
            end else begin
                lock_cnt <= '0;
            end
        end
    end
`else
    logic unused_lock;
    assign lock_seen     = 1'b1;
    assign lock_expired  = 1'b1;
    assign lock_wait_req = 1'b0;
    assign lock_timeout  = '0;
    assign unused_lock   = ^{pll_lock, 32'(LOCK_TIMEOUT)};
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && dev_ok) state_nxt = SETUP;
            SETUP:     if (div_last) state_nxt = SHIFT;
            SHIFT:     if (div_last && phase_high && bit_cnt == 6'd0) state_nxt = HOLD;
            HOLD:      if (div_last) state_nxt = GAP;
            GAP:       if (div_last) state_nxt = lock_wait_req ? LOCK_WAIT : IDLE;
            LOCK_WAIT: if (lock_seen || lock_expired) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Every timed state is a whole number of divider periods, so the divider
    // simply free-runs from zero once a word has been captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            dev        <= '0;
            word       <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            phase_high <= 1'b0;
            err_dev    <= 1'b0;
        end else begin
            err_dev <= accept && !dev_ok;
            if (accept && dev_ok) begin
                dev        <= wr_dev;
                word       <= wr_data;
                bit_cnt    <= 6'd31;
                div_cnt    <= '0;
                phase_high <= 1'b0;
            end else if (frame || state == GAP) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                if (state == SHIFT && div_last) begin
                    phase_high <= !phase_high;
                    if (phase_high && bit_cnt != 6'd0)
                        bit_cnt <= bit_cnt - 6'd1;
                end
            end
        end
    end

    always_comb begin
        wr_ready     = (state == IDLE) && !rst;
        busy         = (state != IDLE);
        adf4159_clk  = '0;
        adf4159_data = '0;
        adf4159_le   = '1;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (frame && dev == 3'(i)) begin
                adf4159_le[i]   = 1'b0;
                adf4159_data[i] = word[bit_cnt[4:0]];
                adf4159_clk[i]  = (state == SHIFT) && phase_high;
            end
        end
    end
endmodule

// File: tb/tb_adf4159_spi_writer.sv
// tb/tb_adf4159_spi_writer.sv - randomized self-checking bench for adf4159_spi_writer
module tb_adf4159_spi_writer;
    localparam int NUM_DEV = 6;
    localparam int D       = 4;
    localparam int LT      = 150;
`ifdef ADF4159_LOCK_WAIT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_valid = 1'b0;
    logic [2:0]         wr_dev = '0;
    logic [31:0]        wr_data = '0;
    logic               wr_ready, busy, err_dev;
    logic [NUM_DEV-1:0] adf_clk, adf_data, adf_le, lock_timeout;
    logic [NUM_DEV-1:0] pll_lock = '0;
    logic [NUM_DEV-1:0] exp_to = '0;
    int                 n_checks = 0;
    int                 n_fail = 0;
    int                 cyc = 0;

    adf4159_spi_writer #(.NUM_DEV(NUM_DEV), .CLK_DIV(D), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_dev(wr_dev), .wr_data(wr_data), .adf4159_clk(adf_clk),
        .adf4159_data(adf_data), .adf4159_le(adf_le), .pll_lock(pll_lock),
        .busy(busy), .err_dev(err_dev), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Cycles from accept until wr_ready returns, from the frame length and lock rules.
    function automatic int exp_ready(input logic [2:0] d, input logic [31:0] w);
        if (LOCK_EN && w[2:0] == 3'b000)
            return 1 + 67 * D + (pll_lock[d] ? 1 : LT);
        return 1 + 67 * D;
    endfunction

    // Presents a word, then watches the pins cycle by cycle until wr_ready returns.
    task automatic run_xfer(input logic [2:0] d, input logic [31:0] w, input bit hold_next,
                            input logic [2:0] nd, input logic [31:0] nw, input int lock_at,
                            output int t_acc, output logic [31:0] got, output int rises,
                            output int first_rise, output int le_rise, output int ready_off,
                            output int other_bad, output int busy_bad, output int glitch);
        logic pclk, pdata, ple;
        wr_valid = 1'b1; wr_dev = d; wr_data = w;
        t_acc = -1; got = '0; rises = 0; first_rise = -1; le_rise = -1;
        ready_off = -1; other_bad = 0; busy_bad = 0; glitch = 0;
        for (int k = 0; k < 1000 && t_acc < 0; k++) begin
            if (wr_ready) t_acc = cyc;
            else tick();
        end
        if (t_acc < 0) return;
        pclk = adf_clk[d]; pdata = adf_data[d]; ple = adf_le[d];
        for (int k = 1; k < 1000; k++) begin
            tick();
            if (hold_next) begin
                wr_valid = 1'b1; wr_dev = nd; wr_data = nw;
            end else begin
                wr_valid = 1'b0; wr_dev = 3'($urandom); wr_data = $urandom;
            end
            if (k == lock_at) pll_lock[d] = 1'b1;
            if (adf_clk[d] && !pclk) begin
                rises++;
                got = {got[30:0], adf_data[d]};
                if (first_rise < 0) first_rise = k;
            end
            if (adf_data[d] !== pdata && k != 1 && !(pclk && !adf_clk[d]) && !(!ple && adf_le[d]))
                glitch++;
            if (adf_le[d] && !ple && le_rise < 0) le_rise = k;
            for (int i = 0; i < NUM_DEV; i++)
                if (i != int'(d) && (adf_clk[i] !== 1'b0 || adf_data[i] !== 1'b0 || adf_le[i] !== 1'b1))
                    other_bad++;
            if (wr_ready) begin
                ready_off = k;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            pclk = adf_clk[d]; pdata = adf_data[d]; ple = adf_le[d];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err_dev !== 1'b0) begin n_fail++; $display("FAIL reset_err_dev got %b want 0", err_dev); end
        n_checks++; if ({adf_clk, adf_data} !== '0) begin n_fail++; $display("FAIL reset_clk_data got %h want 0", {adf_clk, adf_data}); end
        n_checks++; if (adf_le !== '1) begin n_fail++; $display("FAIL reset_le got %b want all 1", adf_le); end
        n_checks++; if (lock_timeout !== '0) begin n_fail++; $display("FAIL reset_lock_timeout got %b want 0", lock_timeout); end
        rst = 1'b0;
        exp_to = '0;
        tick();
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_write_random();
        logic [2:0]  d;
        logic [31:0] w, got;
        int er, t_acc, rises, fr, ler, rdy, ob, bb, gl;
        for (int n = 0; n < 6; n++) begin
            d = (n == 0) ? 3'd2 : 3'($urandom_range(0, NUM_DEV - 1));
            w = (n == 0) ? 32'h1234_5678 : $urandom;
            er = exp_ready(d, w);
            run_xfer(d, w, 1'b0, 3'd0, 32'd0, -1, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
            if (LOCK_EN && w[2:0] == 3'b000) exp_to[d] = !pll_lock[d];
            n_checks++; if (t_acc < 0) begin n_fail++; $display("FAIL wr_accept[%0d] not accepted within bound", n); end
            n_checks++; if (rises !== 32) begin n_fail++; $display("FAIL wr_rises[%0d] got %0d want 32", n, rises); end
            n_checks++; if (got !== w) begin n_fail++; $display("FAIL wr_word[%0d] got %h want %h", n, got, w); end
            n_checks++; if (fr !== 1 + 2 * D) begin n_fail++; $display("FAIL wr_first_rise[%0d] got %0d want %0d", n, fr, 1 + 2 * D); end
            n_checks++; if (ler !== 1 + 66 * D) begin n_fail++; $display("FAIL wr_le_rise[%0d] got %0d want %0d", n, ler, 1 + 66 * D); end
            n_checks++; if (rdy !== er) begin n_fail++; $display("FAIL wr_ready_back[%0d] got %0d want %0d", n, rdy, er); end
            n_checks++; if (ob !== 0) begin n_fail++; $display("FAIL wr_other_pins[%0d] got %0d bad samples want 0", n, ob); end
            n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL wr_busy[%0d] got %0d bad samples want 0", n, bb); end
            n_checks++; if (gl !== 0) begin n_fail++; $display("FAIL wr_data_stable[%0d] got %0d changes want 0", n, gl); end
            n_checks++; if (lock_timeout !== exp_to) begin n_fail++; $display("FAIL wr_lock_timeout[%0d] got %b want %b", n, lock_timeout, exp_to); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb, ga, gb;
        int er, ta, tb, ra, rb, fr, ler, ra_off, rb_off, oba, obb, bb, gl;
        wa = $urandom; wb = $urandom;
        er = exp_ready(3'd0, wa);
        run_xfer(3'd0, wa, 1'b1, 3'd5, wb, -1, ta, ga, ra, fr, ler, ra_off, oba, bb, gl);
        if (LOCK_EN && wa[2:0] == 3'b000) exp_to[0] = !pll_lock[0];
        run_xfer(3'd5, wb, 1'b0, 3'd0, 32'd0, -1, tb, gb, rb, fr, ler, rb_off, obb, bb, gl);
        if (LOCK_EN && wb[2:0] == 3'b000) exp_to[5] = !pll_lock[5];
        n_checks++; if (tb - ta !== er) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", tb - ta, er); end
        n_checks++; if (ga !== wa) begin n_fail++; $display("FAIL b2b_word0 got %h want %h", ga, wa); end
        n_checks++; if (gb !== wb) begin n_fail++; $display("FAIL b2b_word5 got %h want %h", gb, wb); end
        n_checks++; if (oba + obb !== 0) begin n_fail++; $display("FAIL b2b_overlap got %0d bad samples want 0", oba + obb); end
    endtask

    task automatic test_bad_dev();
        int bad;
        for (int n = 6; n <= 7; n++) begin
            bad = 0;
            wr_valid = 1'b1; wr_dev = 3'(n); wr_data = $urandom;
            n_checks++; if (wr_ready !== 1'b1 || err_dev !== 1'b0) begin n_fail++; $display("FAIL bad_dev_pre[%0d] ready %b err %b want 1 0", n, wr_ready, err_dev); end
            tick();
            wr_valid = 1'b0;
            n_checks++; if (err_dev !== 1'b1) begin n_fail++; $display("FAIL bad_dev_pulse[%0d] got %b want 1", n, err_dev); end
            n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL bad_dev_idle[%0d] busy %b ready %b want 0 1", n, busy, wr_ready); end
            tick();
            n_checks++; if (err_dev !== 1'b0) begin n_fail++; $display("FAIL bad_dev_one_cycle[%0d] got %b want 0", n, err_dev); end
            for (int k = 0; k < 10; k++) begin
                if (adf_clk !== '0 || adf_data !== '0 || adf_le !== '1 || busy !== 1'b0) bad++;
                tick();
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bad_dev_pins[%0d] got %0d bad samples want 0", n, bad); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0]  d;
        logic [31:0] w, got;
        int t_acc, rises, fr, ler, rdy, ob, bb, gl;
        d = 3'($urandom_range(0, NUM_DEV - 1));
        w = $urandom;
        wr_valid = 1'b1; wr_dev = d; wr_data = w;
        t_acc = -1;
        for (int k = 0; k < 1000 && t_acc < 0; k++) begin
            if (wr_ready) t_acc = cyc;
            else tick();
        end
        n_checks++; if (t_acc < 0) begin n_fail++; $display("FAIL rst_mid_accept not accepted within bound"); end
        for (int k = 1; k <= 1 + 34 * D; k++) begin
            tick();
            wr_valid = 1'b0;
        end
        n_checks++; if (adf_clk[d] !== 1'b1 || adf_data[d] !== w[15]) begin n_fail++; $display("FAIL rst_mid_bit15 clk %b data %b want 1 %b", adf_clk[d], adf_data[d], w[15]); end
        rst = 1'b1;
        tick();
        n_checks++; if (adf_le !== '1 || adf_clk !== '0 || adf_data !== '0) begin n_fail++; $display("FAIL rst_mid_pins le %b clk %b data %b want all1 0 0", adf_le, adf_clk, adf_data); end
        n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_status busy %b ready %b want 0 0", busy, wr_ready); end
        rst = 1'b0;
        exp_to = '0;
        tick();
        w = $urandom;
        run_xfer(d, w, 1'b0, 3'd0, 32'd0, -1, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
        n_checks++; if (got !== w || rises !== 32) begin n_fail++; $display("FAIL rst_mid_rewrite got %h/%0d want %h/32", got, rises, w); end
    endtask

`ifdef ADF4159_LOCK_WAIT_EN
    task automatic test_lock();
        logic [31:0] w, got;
        int t_acc, rises, fr, ler, rdy, ob, bb, gl, lat;
        pll_lock[1] = 1'b0;
        lat = 1 + 67 * D + 100;
        run_xfer(3'd1, 32'h0000_0000, 1'b0, 3'd0, 32'd0, lat, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
        exp_to[1] = 1'b0;
        n_checks++; if (rdy - lat < 2 || rdy - lat > 3) begin n_fail++; $display("FAIL lock_release got %0d cycles after lock want 2..3", rdy - lat); end
        n_checks++; if (lock_timeout !== exp_to) begin n_fail++; $display("FAIL lock_ok_flags got %b want %b", lock_timeout, exp_to); end
        pll_lock[3] = 1'b0;
        w = {$urandom_range(0, 32'h1FFF_FFFF), 3'b000};
        run_xfer(3'd3, w, 1'b0, 3'd0, 32'd0, -1, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
        exp_to[3] = 1'b1;
        n_checks++; if (rdy !== 1 + 67 * D + LT) begin n_fail++; $display("FAIL lock_timeout_len got %0d want %0d", rdy, 1 + 67 * D + LT); end
        n_checks++; if (lock_timeout !== exp_to) begin n_fail++; $display("FAIL lock_timeout_set got %b want %b", lock_timeout, exp_to); end
        for (int k = 0; k < 20; k++) tick();
        w = {$urandom_range(0, 32'h1FFF_FFFF), 3'($urandom_range(1, 7))};
        run_xfer(3'd3, w, 1'b0, 3'd0, 32'd0, -1, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
        n_checks++; if (rdy !== 1 + 67 * D) begin n_fail++; $display("FAIL lock_skip_non_r0 got %0d want %0d", rdy, 1 + 67 * D); end
        n_checks++; if (lock_timeout !== exp_to) begin n_fail++; $display("FAIL lock_timeout_sticky got %b want %b", lock_timeout, exp_to); end
    endtask
`else
    task automatic test_no_lock();
        logic [31:0] got;
        int t_acc, rises, fr, ler, rdy, ob, bb, gl;
        run_xfer(3'd4, 32'h0000_0000, 1'b0, 3'd0, 32'd0, -1, t_acc, got, rises, fr, ler, rdy, ob, bb, gl);
        n_checks++; if (rdy !== 1 + 67 * D) begin n_fail++; $display("FAIL no_lock_r0_len got %0d want %0d", rdy, 1 + 67 * D); end
        n_checks++; if (lock_timeout !== '0) begin n_fail++; $display("FAIL no_lock_flags got %b want 0", lock_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_random();
        test_back_to_back();
        test_bad_dev();
        test_reset_mid();
`ifdef ADF4159_LOCK_WAIT_EN
        test_lock();
`else
        test_no_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time bound at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
